// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: per-index 2-bit saturating counters plus a tagged direct-mapped BTB.
// Defining BP_STATS_EN adds the stat_branches / stat_mispredicts counter outputs.
module branch_predictor #(
  parameter int IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS - 2;

  logic [1:0]       cnt_q   [ENTRIES];
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, ex_idx;
  logic [TAG_W-1:0]    f_tag, ex_tag;
  logic                update;
  logic [1:0]          cnt_ex, cnt_d;
  logic                unused_pc_bits;

  assign f_idx          = pc_f[IDX_BITS+1:2];
  assign f_tag          = pc_f[31:IDX_BITS+2];
  assign ex_idx         = ex_pc[IDX_BITS+1:2];
  assign ex_tag         = ex_pc[31:IDX_BITS+2];
  assign unused_pc_bits = ^{pc_f[1:0], ex_pc[1:0]};

  assign update = ex_valid & ex_is_branch;

  // Reads see only registered state, so a same-cycle write is invisible until the next cycle.
  always_comb begin
    pred_taken  = cnt_q[f_idx][1] & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
    pred_target = pred_taken ? tgt_q[f_idx] : pc_f + 32'd4;
  end

  always_comb begin
    cnt_ex = cnt_q[ex_idx];
    cnt_d  = cnt_ex;
    if (ex_taken) begin
      if (cnt_ex != 2'b11) cnt_d = cnt_ex + 2'd1;
    end else begin
      if (cnt_ex != 2'b00) cnt_d = cnt_ex - 2'd1;
    end
  end

  always_comb begin
    mispredict  = update & ((ex_taken != ex_pred_taken) |
                            (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
    redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i]   <= 2'b01;
        valid_q[i] <= 1'b0;
      end
    end else if (update) begin
      cnt_q[ex_idx] <= cnt_d;
      if (ex_taken) valid_q[ex_idx] <= 1'b1;
    end
  end

  // Tag and target storage carries no reset; the valid bit gates its use.
  always_ff @(posedge clk) begin
    if (!rst && update && ex_taken) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= ex_target;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_mispredicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_q + {31'd0, update};
      stat_mispredicts_q <= stat_mispredicts_q + {31'd0, mispredict};
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 6, meaning log2 of the BHT/BTB entry count (64 entries).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning the synchronous, active-high reset.
REQ-004 SHALL have port pc_f  input  32  meaning the fetch-stage PC to predict.
REQ-005 SHALL have port pred_taken  output  1  meaning predict taken for pc_f.
REQ-006 SHALL have port pred_target  output  32  meaning the predicted target; pc_f+4 when not predicted taken.
REQ-007 SHALL have port ex_valid  input  1  meaning the execute-stage instruction is valid (not flushed).
REQ-008 SHALL have port ex_is_branch  input  1  meaning the execute instruction is a conditional branch.
REQ-009 SHALL have port ex_pc  input  32  meaning the PC of the execute instruction.
REQ-010 SHALL have port ex_taken  input  1  meaning the resolved branch outcome (the is_branch_jump result).
REQ-011 SHALL have port ex_target  input  32  meaning the resolved branch target address.
REQ-012 SHALL have port ex_pred_taken  input  1  meaning the pred_taken value carried down the pipeline with the instruction.
REQ-013 SHALL have port ex_pred_target  input  32  meaning the pred_target value carried down the pipeline with the instruction.
REQ-014 SHALL have port mispredict  output  1  meaning flush younger instructions and redirect fetch.
REQ-015 SHALL have port redirect_pc  output  32  meaning the correct next PC when mispredict is 1.

Function
REQ-016 SHALL index both tables with pc[IDX_BITS+1:2]; BTB tag = pc[31:IDX_BITS+2].
REQ-017 SHALL hold per entry: 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST), BTB valid bit, tag, target[31:0].
REQ-018 SHALL assert pred_taken combinationally in the same cycle as pc_f when counter[1]=1 AND the BTB entry is valid AND its tag matches; otherwise pred_taken=0.
REQ-019 SHALL drive pred_target = BTB target when pred_taken=1, else pc_f+4 (mod 2^32).
REQ-020 SHALL define update = ex_valid & ex_is_branch; with no update, no table state changes.
REQ-021 SHALL, on update, increment the counter at the ex_pc index if ex_taken=1 (saturate at 11) and decrement it if ex_taken=0 (saturate at 00), visible from the next cycle.
REQ-022 SHALL, on update with ex_taken=1, write valid=1, the tag, and ex_target into the BTB entry, replacing any aliasing entry.
REQ-023 SHALL NOT modify the BTB on update with ex_taken=0.
REQ-024 SHALL, when the same index is read on pc_f and written in one cycle, predict from the pre-update contents.
REQ-025 SHALL compute mispredict combinationally = update & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & (ex_target != ex_pred_target))).
REQ-026 SHALL drive redirect_pc = ex_taken ? ex_target : ex_pc+4; its value is don't-care when mispredict=0.
REQ-027 SHALL force mispredict=0 whenever ex_valid=0, regardless of the other ex_* inputs.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set all counters to 01 (WNT) and clear all BTB valid bits; tags and targets need not be reset.
REQ-029 SHALL give update no effect in a cycle where rst=1; reset has priority.
REQ-030 SHALL ensure that after reset pred_taken=0 and pred_target=pc_f+4 for every pc_f; mispredict is determined purely by its inputs.

Configuration
REQ-031 SHALL, with BP_STATS_EN defined, add outputs stat_branches[31:0] (+1 per update) and stat_mispredicts[31:0] (+1 per cycle with mispredict=1). Both counters wrap at 2^32 and are cleared to 0 by rst.
REQ-032 SHALL, with BP_STATS_EN undefined, omit those ports and counters entirely; predictor behaviour is identical in both builds.

Verification
REQ-033 SHALL cover: after reset, pc_f=0x100 -> pred_taken=0, pred_target=0x104.
REQ-034 SHALL cover: two taken updates at ex_pc=0x100, ex_target=0x40, then pc_f=0x100 -> pred_taken=1, pred_target=0x40. After a third taken update the counter stays at 11; two not-taken updates then give pred_taken=0.
REQ-035 SHALL cover: an update with ex_taken=1, ex_pred_taken=0, ex_pc=0x200, ex_target=0x80 -> mispredict=1, redirect_pc=0x80. The same inputs with ex_valid=0 -> mispredict=0.
REQ-036 SHALL cover: ex_taken=0, ex_pred_taken=1, ex_pc=0x200 -> mispredict=1, redirect_pc=0x204. Taken with matching target 0x80 -> mispredict=0; target mismatch 0x84 vs 0x80 -> mispredict=1.
REQ-037 SHALL cover: aliasing, with 0x100 trained taken, then pc_f=0x200 (same index, different tag) -> pred_taken=0. The same-cycle read/write of index 0x100 returns the old prediction.
REQ-038 SHALL cover: with BP_STATS_EN, 5 updates including 2 mispredicts -> stat_branches=5, stat_mispredicts=2. Asserting rst mid-stream clears both counters and all predictions.
